ifetch_prefetch: RTL and testbench
==================================

Name: ifetch_prefetch

Overview:
Instruction-fetch front end that sits directly upstream of the MIPS core's decode/execute datapath. It runs a sequential fetch PC and issues word reads to a slow instruction memory over a req/ack handshake. Returned words are buffered, each with its PC, in a small FIFO, and presented to the core through a valid/ready interface. Taken branches from the core redirect fetch, flush the FIFO and discard any in-flight read.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
mem_req  output  1  read request to instruction memory
mem_addr  output  32  word address of request; bits [1:0] always 0
mem_ack  input  1  one-cycle pulse; mem_rdata valid in that cycle
mem_rdata  input  32  instruction word returned with mem_ack
instr_valid  output  1  FIFO head holds a valid instruction
instr  output  32  instruction at FIFO head
instr_pc  output  32  PC of instruction at FIFO head
instr_ready  input  1  core consumes head this cycle when instr_valid=1
redirect  input  1  one-cycle pulse: flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)

Behaviour:
- Reset (reset=0, asynchronous): fetch_pc=RESET_PC, state=IDLE, FIFO count=0, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- States: IDLE (no read outstanding), REQ (read outstanding, data kept), DISCARD (read outstanding, data dropped).
- IDLE -> REQ when count<DEPTH and redirect=0; mem_req=1, mem_addr=fetch_pc registered.
- mem_req and mem_addr hold stable in REQ/DISCARD until the cycle in which mem_ack=1. mem_ack while IDLE is ignored.
- REQ with mem_ack and no redirect: push {fetch_pc, mem_rdata}; fetch_pc+=4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
  - Next state is REQ with the new address (back-to-back, mem_req stays 1) if post-cycle count<DEPTH; else IDLE.
- Pop: instr_valid=1 and instr_ready=1 removes the head. Push and pop in the same cycle leave count unchanged. A push when full is impossible by construction; the bench asserts it never occurs.
- Issue rule: at most one read outstanding. A new read only when post-cycle count<DEPTH, so an ack always has room.
- Redirect (highest priority):
  - Same cycle: FIFO cleared (count=0, instr_valid=0 next cycle), a simultaneous pop is ignored, fetch_pc={redirect_pc[31:2],2'b00}.
  - From IDLE: next state REQ at the new pc, mem_req=1 next cycle.
  - From REQ without mem_ack: next state DISCARD.
  - From REQ or DISCARD with mem_ack in the same cycle: the ack data is dropped and the next state is REQ at the new pc.
- DISCARD: on mem_ack, drop the data and go to REQ at fetch_pc. A further redirect in DISCARD only updates fetch_pc.
- Latency: from redirect (or reset release) to instr_valid = 1 cycle to issue + memory latency + 1 cycle to FIFO output. Zero-wait memory (ack on the first req cycle) gives instr_valid 2 cycles after redirect.
- instr/instr_pc are registered FIFO head outputs, stable while instr_valid=1 and not popped. Their value is don't-care when instr_valid=0, except after reset, where they are 0.
- Reset asserted mid-transaction drops everything immediately; the memory model must tolerate mem_req falling before ack.

Test Plan:
- Reset release, memory acks 1 cycle after every req, instr_ready=1 -> mem_addr 0,4,8,...; core sees instr_pc 0,4,8 in order with the matching instr words; no gaps after the first.
- instr_ready=0, DEPTH=4 -> exactly 4 reads issued (0x0..0xC), then mem_req=0; raising instr_ready for 1 cycle -> pops pc 0x0, next req at 0x10.
- redirect to 0x0000_0103 while a read of 0x8 is outstanding, memory acks 3 cycles later -> that word is dropped; next mem_addr=0x100; first delivered instr_pc=0x100.
- redirect in the same cycle as mem_ack and pop with FIFO holding 2 entries -> count=0 next cycle, ack data not delivered, next req 0x100.
- redirect_pc=0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
- reset pulsed low between clock edges during an outstanding read -> outputs return to reset values immediately; fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/ifetch_prefetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ifetch_prefetch
//  Purpose  : Sequential instruction prefetcher. Issues one word read at a
//             time to a slow memory over req/ack and buffers the returned
//             words with their PCs in a small FIFO. Redirects flush the FIFO
//             and drop any in-flight read.
//  Revision : 1.0  initial release
// ============================================================================
module ifetch_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] C_DEPTH    = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_DEPTH_M1 = (AW+1)'(DEPTH - 1);
   localparam logic [31:0] C_PC_STEP  = 32'd4;

   // IDLE: nothing outstanding; REQ: read outstanding, data kept;
   // DISCARD: read outstanding, data dropped when it returns.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   count_pop;
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   data_mem_q [DEPTH];
   logic          push;
   logic          pop;
   logic [31:0]   redirect_pc_al;

   assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;
   // A redirect wins over a pop in the same cycle.
   assign pop            = (count_q != '0) && instr_ready && !redirect;
   assign count_pop      = count_q - {{AW{1'b0}}, pop};

   assign mem_req     = (state_q != S_IDLE);
   assign mem_addr    = mem_addr_q;
   assign instr_valid = (count_q != '0);
   assign instr       = data_mem_q[rd_ptr_q];
   assign instr_pc    = pc_mem_q[rd_ptr_q];

   // Fetch FSM next state: issue rule uses the post-cycle occupancy so an ack always has room.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_addr_d = mem_addr_q;
      push       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (redirect) begin
               fetch_pc_d = redirect_pc_al;
               mem_addr_d = redirect_pc_al;
               state_d    = S_REQ;
            end else if (count_pop < C_DEPTH) begin
               mem_addr_d = fetch_pc_q;
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            if (redirect) begin
               fetch_pc_d = redirect_pc_al;
               if (mem_ack) begin
                  mem_addr_d = redirect_pc_al;
                  state_d    = S_REQ;
               end else begin
                  state_d    = S_DISCARD;
               end
            end else if (mem_ack) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + C_PC_STEP;
               // After this push the count is count_pop+1; reissue only if still below DEPTH.
               if (count_pop < C_DEPTH_M1) begin
                  mem_addr_d = fetch_pc_q + C_PC_STEP;
                  state_d    = S_REQ;
               end else begin
                  state_d    = S_IDLE;
               end
            end
         end
         S_DISCARD: begin
            if (redirect) begin
               fetch_pc_d = redirect_pc_al;
            end
            if (mem_ack) begin
               mem_addr_d = redirect ? redirect_pc_al : fetch_pc_q;
               state_d    = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
      count_d = redirect ? '0 : (count_pop + {{AW{1'b0}}, push});
   end

   // Control state, fetch PC, request address and FIFO pointers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         mem_addr_q <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
         count_q    <= count_d;
         if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // FIFO storage; cleared on reset so the head outputs read as zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            data_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
         data_mem_q[wr_ptr_q] <= mem_rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch_prefetch
//  Purpose  : Self-checking bench for ifetch_prefetch: directed scenarios
//             plus a randomized run against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifetch_prefetch;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;

   int n_cmp  = 0;
   int n_fail = 0;

   // memory model controls
   int mem_lat  = 0;
   bit mem_rand = 1'b0;
   int wait_cnt = 0;
   int cur_lat  = 0;

   ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Slow memory: acks the current request after cur_lat extra cycles; tolerates req dropping.
   always begin
      @(posedge clk);
      #2;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (!reset || !mem_req) begin
         wait_cnt = 0;
      end else begin
         if (wait_cnt == 0) cur_lat = mem_rand ? $urandom_range(0, 3) : mem_lat;
         if (wait_cnt == cur_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = word_of(mem_addr);
            wait_cnt  = 0;
         end else begin
            wait_cnt = wait_cnt + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at +1 of cycle 0: reset released, first active edge ahead.
   task automatic do_reset();
      reset       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      reset = 1'b0;
      tick();
      tick();
      #2;
      n_cmp++; if (mem_req !== 1'b0)       begin n_fail++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
      n_cmp++; if (mem_addr !== 32'h0)     begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
      n_cmp++; if (instr_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
      n_cmp++; if (instr !== 32'h0)        begin n_fail++; $display("FAIL reset_instr got %h want 0", instr); end
      n_cmp++; if (instr_pc !== 32'h0)     begin n_fail++; $display("FAIL reset_instr_pc got %h want 0", instr_pc); end
      tick();
   endtask

   task automatic test_stream();
      logic [31:0] ea, ep;
      mem_rand = 1'b0; mem_lat = 0;
      do_reset();
      instr_ready = 1'b1;
      for (int n = 0; n < 12; n++) begin
         #2;
         if (n == 0) begin
            n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL stream_first_req got %0b want 0", mem_req); end
         end else begin
            ea = 32'(4 * (n - 1));
            n_cmp++; if ({mem_req, mem_addr} !== {1'b1, ea}) begin n_fail++; $display("FAIL stream_req cyc %0d got req=%0b addr=%h want req=1 addr=%h", n, mem_req, mem_addr, ea); end
         end
         if (n >= 2) begin
            ep = 32'(4 * (n - 2));
            n_cmp++; if ({instr_valid, instr_pc, instr} !== {1'b1, ep, word_of(ep)}) begin n_fail++; $display("FAIL stream_out cyc %0d got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", n, instr_valid, instr_pc, instr, ep, word_of(ep)); end
         end
         tick();
      end
      instr_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int issued;
      mem_rand = 1'b0; mem_lat = 0;
      do_reset();
      instr_ready = 1'b0;
      issued = 0;
      for (int n = 0; n < 12; n++) begin
         #2;
         if (mem_req && mem_ack) begin
            n_cmp++; if (mem_addr !== 32'(issued * 4)) begin n_fail++; $display("FAIL bp_addr got %h want %h", mem_addr, 32'(issued * 4)); end
            issued++;
         end
         tick();
      end
      #2;
      n_cmp++; if (issued != DEPTH)       begin n_fail++; $display("FAIL bp_issued got %0d want %0d", issued, DEPTH); end
      n_cmp++; if (mem_req !== 1'b0)      begin n_fail++; $display("FAIL bp_req_full got %0b want 0", mem_req); end
      n_cmp++; if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL bp_head got v=%0b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
      tick();
      instr_ready = 1'b1;
      #2;
      tick();
      instr_ready = 1'b0;
      #2;
      n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL bp_reissue got req=%0b addr=%h want req=1 addr=10", mem_req, mem_addr); end
      n_cmp++; if ({instr_valid, instr_pc} !== {1'b1, 32'h4}) begin n_fail++; $display("FAIL bp_after_pop got v=%0b pc=%h want v=1 pc=4", instr_valid, instr_pc); end
      tick();
   endtask

   task automatic test_redirect_discard();
      bit found, got, seen_new;
      mem_rand = 1'b0; mem_lat = 3;
      do_reset();
      instr_ready = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 50 && !found; n++) begin
         #2;
         if (mem_req && mem_addr == 32'h8) found = 1'b1;
         else tick();
      end
      n_cmp++; if (!found) begin n_fail++; $display("FAIL rd_wait_req8 got none want req at 8"); end
      tick();
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      #2;
      tick();
      redirect = 1'b0;
      got = 1'b0; seen_new = 1'b0;
      for (int n = 0; n < 60 && !got; n++) begin
         #2;
         if (mem_req && !seen_new && mem_addr != 32'h8) begin
            seen_new = 1'b1;
            n_cmp++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL rd_next_addr got %h want 100", mem_addr); end
         end
         if (instr_valid) got = 1'b1;
         else tick();
      end
      n_cmp++; if (!seen_new) begin n_fail++; $display("FAIL rd_new_req got none want req at 100"); end
      n_cmp++; if ({got, instr_pc, instr} !== {1'b1, 32'h100, word_of(32'h100)}) begin n_fail++; $display("FAIL rd_first_out got v=%0b pc=%h instr=%h want pc=100 instr=%h", got, instr_pc, instr, word_of(32'h100)); end
      tick();
      instr_ready = 1'b0;
   endtask

   task automatic test_redirect_ack_pop();
      mem_rand = 1'b0; mem_lat = 0;
      do_reset();
      instr_ready = 1'b0;
      tick(); tick(); tick();
      redirect = 1'b1; redirect_pc = 32'h0000_0100; instr_ready = 1'b1;
      #2;
      n_cmp++; if ({mem_req, mem_ack, mem_addr} !== {2'b11, 32'h8}) begin n_fail++; $display("FAIL rap_pre_ack got req=%0b ack=%0b addr=%h want 1 1 8", mem_req, mem_ack, mem_addr); end
      n_cmp++; if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL rap_pre_head got v=%0b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
      tick();
      redirect = 1'b0; instr_ready = 1'b0;
      #2;
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rap_flushed got v=%0b want 0", instr_valid); end
      n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL rap_next_req got req=%0b addr=%h want 1 100", mem_req, mem_addr); end
      tick();
      #2;
      n_cmp++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, word_of(32'h100)}) begin n_fail++; $display("FAIL rap_out got v=%0b pc=%h instr=%h want pc=100", instr_valid, instr_pc, instr); end
      tick();
   endtask

   task automatic test_wrap();
      mem_rand = 1'b0; mem_lat = 0;
      do_reset();
      instr_ready = 1'b1;
      repeat (4) tick();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      #2;
      tick();
      redirect = 1'b0;
      #2;
      n_cmp++; if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin n_fail++; $display("FAIL wrap_req0 got req=%0b addr=%h v=%0b want 1 fffffffc 0", mem_req, mem_addr, instr_valid); end
      tick();
      #2;
      n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wrap_req1 got req=%0b addr=%h want 1 0", mem_req, mem_addr); end
      n_cmp++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'hFFFF_FFFC, word_of(32'hFFFF_FFFC)}) begin n_fail++; $display("FAIL wrap_out0 got v=%0b pc=%h instr=%h want pc=fffffffc", instr_valid, instr_pc, instr); end
      tick();
      #2;
      n_cmp++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, word_of(32'h0)}) begin n_fail++; $display("FAIL wrap_out1 got v=%0b pc=%h instr=%h want pc=0", instr_valid, instr_pc, instr); end
      tick();
      instr_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      bit found, seen;
      mem_rand = 1'b0; mem_lat = 4;
      do_reset();
      instr_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h0000_0040;
      tick();
      redirect = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         #2;
         if (instr_valid && mem_req && !mem_ack) found = 1'b1;
         else tick();
      end
      n_cmp++; if ({found, instr_pc} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL ar_pre got found=%0b pc=%h want 1 40", found, instr_pc); end
      #1;
      reset = 1'b0;
      #1;
      n_cmp++; if ({mem_req, mem_addr} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL ar_req got req=%0b addr=%h want 0 0", mem_req, mem_addr); end
      n_cmp++; if ({instr_valid, instr, instr_pc} !== {1'b0, 32'h0, 32'h0}) begin n_fail++; $display("FAIL ar_out got v=%0b instr=%h pc=%h want 0 0 0", instr_valid, instr, instr_pc); end
      tick();
      reset = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 4 && !seen; n++) begin
         #2;
         if (mem_req) begin
            seen = 1'b1;
            n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_restart_addr got %h want 0", mem_addr); end
         end
         tick();
      end
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL ar_restart got no req want req"); end
   endtask

   task automatic test_random();
      logic [31:0] q_pc[$];
      logic [31:0] q_data[$];
      logic [31:0] exp_fetch, rpc, c_addr, prev_addr;
      bit live, prev_req, prev_ack, first;
      bit c_req, c_ack, c_redir, c_ready, c_valid, do_pop;
      mem_rand = 1'b1;
      do_reset();
      exp_fetch = 32'h0; live = 1'b0;
      prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; first = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         instr_ready = ($urandom_range(0, 99) < 65);
         redirect    = ($urandom_range(0, 99) < 4);
         case ($urandom_range(0, 2))
            0:       rpc = $urandom;
            1:       rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            default: rpc = $urandom_range(0, 255);
         endcase
         redirect_pc = rpc;
         #2;
         c_req = mem_req; c_ack = mem_ack; c_addr = mem_addr;
         c_redir = redirect; c_ready = instr_ready; c_valid = instr_valid;
         // outputs versus the buffered stream
         n_cmp++; if (c_valid !== (q_pc.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", cyc, c_valid, (q_pc.size() != 0)); end
         if (q_pc.size() != 0) begin
            n_cmp++; if ({instr_pc, instr} !== {q_pc[0], q_data[0]}) begin n_fail++; $display("FAIL rnd_head cyc %0d got pc=%h instr=%h want pc=%h instr=%h", cyc, instr_pc, instr, q_pc[0], q_data[0]); end
         end
         // request protocol: outstanding reads hold, otherwise issue whenever there is room
         if (prev_req && !prev_ack) begin
            n_cmp++; if ({c_req, c_addr} !== {1'b1, prev_addr}) begin n_fail++; $display("FAIL rnd_hold cyc %0d got req=%0b addr=%h want 1 %h", cyc, c_req, c_addr, prev_addr); end
         end else if (!first) begin
            n_cmp++; if (c_req !== (q_pc.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_issue cyc %0d got req=%0b want %0b", cyc, c_req, (q_pc.size() < DEPTH)); end
            if (c_req) begin
               n_cmp++; if (c_addr !== exp_fetch) begin n_fail++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, c_addr, exp_fetch); end
               n_cmp++; if (q_pc.size() >= DEPTH) begin n_fail++; $display("FAIL rnd_room cyc %0d got count %0d want <%0d", cyc, q_pc.size(), DEPTH); end
               live = 1'b1;
            end
         end
         // model update for the coming edge
         do_pop = (q_pc.size() != 0) && c_ready && !c_redir;
         if (c_redir) begin
            q_pc.delete(); q_data.delete();
            exp_fetch = {rpc[31:2], 2'b00};
            live = 1'b0;
         end else begin
            if (do_pop) begin
               void'(q_pc.pop_front()); void'(q_data.pop_front());
            end
            if (c_ack && live) begin
               n_cmp++; if (q_pc.size() >= DEPTH) begin n_fail++; $display("FAIL rnd_push_full cyc %0d got count %0d want <%0d", cyc, q_pc.size(), DEPTH); end
               q_pc.push_back(c_addr);
               q_data.push_back(word_of(c_addr));
               exp_fetch = exp_fetch + 32'd4;
               live = 1'b0;
            end
         end
         prev_req = c_req; prev_ack = c_ack; prev_addr = c_addr; first = 1'b0;
         tick();
      end
      redirect = 1'b0; instr_ready = 1'b0; mem_rand = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_discard();
      test_redirect_ack_pop();
      test_wrap();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
